// File: rtl/multicycle_controller.sv
// Multi-cycle control unit: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB over a shared memory with a ready handshake,
// with a memory-wait timeout and a sticky error state.
module multicycle_controller #(
  parameter int TIMEOUT = 15,
  parameter int WAIT_W  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_op,
  input  logic [2:0] i_f3,
  input  logic       i_zero,
  input  logic       i_sign_bit,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic       o_adr_sel,
  output logic       o_ir_we,
  output logic       o_pc_we,
  output logic [1:0] o_pc_src,
  output logic [2:0] o_imm_sel,
  output logic       o_alu_sel,
  output logic [2:0] o_alu_op,
  output logic       o_reg_we,
  output logic [1:0] o_result_sel,
  output logic       o_instr_done,
  output logic       o_err,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [6:0] OP_R    = 7'd0;
  localparam logic [6:0] OP_LW   = 7'd1;
  localparam logic [6:0] OP_ADDI = 7'd2;
  localparam logic [6:0] OP_XORI = 7'd3;
  localparam logic [6:0] OP_ORI  = 7'd4;
  localparam logic [6:0] OP_SLTI = 7'd5;
  localparam logic [6:0] OP_JALR = 7'd6;
  localparam logic [6:0] OP_SW   = 7'd7;
  localparam logic [6:0] OP_JAL  = 7'd8;
  localparam logic [6:0] OP_BEQ  = 7'd9;
  localparam logic [6:0] OP_BNE  = 7'd10;
  localparam logic [6:0] OP_BLT  = 7'd11;
  localparam logic [6:0] OP_BGE  = 7'd12;
  localparam logic [6:0] OP_LUI  = 7'd13;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_IMM = 2'b10;
  localparam logic [1:0] RES_PC4 = 2'b11;

  // Last wait-count value before a stalled request times out; unused when TIMEOUT=0.
  localparam logic [WAIT_W-1:0] W_LAST = (TIMEOUT == 0) ? '0 : WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] W_MAX  = '1;

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait;

  logic       w_legal, w_branch, w_taken, w_use_imm;
  logic [2:0] w_imm_type, w_alu_code;
  logic [1:0] w_res_code;
  logic       w_waiting, w_timeout;

  logic       w_mem_req, w_mem_we, w_adr_sel, w_ir_we, w_pc_we;
  logic [1:0] w_pc_src, w_result_sel;
  logic [2:0] w_imm_sel, w_alu_op;
  logic       w_alu_sel, w_reg_we, w_instr_done;

  // Per-opcode attributes: immediate format, ALU operation, writeback source, branch outcome.
  always_comb begin
    w_legal    = 1'b1;
    w_branch   = 1'b0;
    w_taken    = 1'b0;
    w_use_imm  = 1'b0;
    w_imm_type = IMM_I;
    w_alu_code = ALU_ADD;
    w_res_code = RES_ALU;
    case (i_op)
      OP_R:    w_alu_code = i_f3;
      OP_LW:   begin w_use_imm = 1'b1; w_res_code = RES_MEM; end
      OP_ADDI: w_use_imm = 1'b1;
      OP_XORI,
      OP_ORI:  begin w_use_imm = 1'b1; w_alu_code = i_f3; end
      OP_SLTI: begin w_use_imm = 1'b1; w_alu_code = ALU_SUB; w_res_code = RES_IMM; end
      OP_JALR: begin w_use_imm = 1'b1; w_res_code = RES_PC4; end
      OP_SW:   begin w_use_imm = 1'b1; w_imm_type = IMM_S; end
      OP_JAL:  begin w_imm_type = IMM_J; w_res_code = RES_PC4; end
      OP_BEQ:  begin w_branch = 1'b1; w_taken = i_zero;      w_imm_type = IMM_B; w_alu_code = ALU_SUB; end
      OP_BNE:  begin w_branch = 1'b1; w_taken = ~i_zero;     w_imm_type = IMM_B; w_alu_code = ALU_SUB; end
      OP_BLT:  begin w_branch = 1'b1; w_taken = i_sign_bit;  w_imm_type = IMM_B; w_alu_code = ALU_SUB; end
      OP_BGE:  begin w_branch = 1'b1; w_taken = ~i_sign_bit; w_imm_type = IMM_B; w_alu_code = ALU_SUB; end
      OP_LUI:  begin w_imm_type = IMM_U; w_res_code = RES_IMM; end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_waiting = w_mem_req & ~i_mem_ready;
  assign w_timeout = (TIMEOUT != 0) && w_waiting && (r_wait == W_LAST);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Wait counter: counts stalled request cycles, saturates, and restarts whenever no request is stalled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                 r_wait <= '0;
    else if (!w_waiting)       r_wait <= '0;
    else if (r_wait != W_MAX)  r_wait <= r_wait + WAIT_W'(1);
  end

  // Next-state and per-state control outputs.
  always_comb begin
    w_next       = r_state;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_adr_sel    = 1'b0;
    w_ir_we      = 1'b0;
    w_pc_we      = 1'b0;
    w_pc_src     = 2'b00;
    w_imm_sel    = IMM_I;
    w_alu_sel    = 1'b0;
    w_alu_op     = ALU_ADD;
    w_reg_we     = 1'b0;
    w_result_sel = RES_ALU;
    w_instr_done = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (i_mem_ready) begin
          w_ir_we = 1'b1;
          w_pc_we = 1'b1;
          w_next  = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_ERR;
        end
      end
      S_DECODE: begin
        w_imm_sel = w_imm_type;
        w_next    = w_legal ? S_EXEC : S_ERR;
      end
      S_EXEC: begin
        w_imm_sel = w_imm_type;
        w_alu_sel = w_use_imm;
        w_alu_op  = w_alu_code;
        if (w_branch) begin
          w_pc_we      = w_taken;
          w_pc_src     = 2'b01;
          w_instr_done = 1'b1;
          w_next       = S_FETCH;
        end else if (i_op == OP_JAL) begin
          w_pc_we  = 1'b1;
          w_pc_src = 2'b01;
          w_next   = S_WB;
        end else if (i_op == OP_JALR) begin
          w_pc_we  = 1'b1;
          w_pc_src = 2'b10;
          w_next   = S_WB;
        end else if (i_op == OP_LW || i_op == OP_SW) begin
          w_next = S_MEM;
        end else if (w_legal) begin
          w_next = S_WB;
        end else begin
          w_next = S_ERR;
        end
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_adr_sel = 1'b1;
        w_mem_we  = (i_op == OP_SW);
        if (i_mem_ready) begin
          w_instr_done = (i_op == OP_SW);
          w_next       = (i_op == OP_SW) ? S_FETCH : S_WB;
        end else if (w_timeout) begin
          w_next = S_ERR;
        end
      end
      S_WB: begin
        w_reg_we     = 1'b1;
        w_instr_done = 1'b1;
        w_result_sel = w_res_code;
        w_next       = S_FETCH;
      end
      S_ERR:   w_next = S_ERR;
      default: w_next = S_ERR;
    endcase
  end

  assign o_mem_req    = i_rst ? 1'b0  : w_mem_req;
  assign o_mem_we     = i_rst ? 1'b0  : w_mem_we;
  assign o_adr_sel    = i_rst ? 1'b0  : w_adr_sel;
  assign o_ir_we      = i_rst ? 1'b0  : w_ir_we;
  assign o_pc_we      = i_rst ? 1'b0  : w_pc_we;
  assign o_pc_src     = i_rst ? 2'b00 : w_pc_src;
  assign o_imm_sel    = i_rst ? 3'b000 : w_imm_sel;
  assign o_alu_sel    = i_rst ? 1'b0  : w_alu_sel;
  assign o_alu_op     = i_rst ? 3'b000 : w_alu_op;
  assign o_reg_we     = i_rst ? 1'b0  : w_reg_we;
  assign o_result_sel = i_rst ? 2'b00 : w_result_sel;
  assign o_instr_done = i_rst ? 1'b0  : w_instr_done;
  assign o_err        = i_rst ? 1'b0  : (r_state == S_ERR);
  assign o_state      = i_rst ? 3'b000 : r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction phase sequences with random
// wait states and flags, checked every cycle against a table-driven model.
module tb_multicycle_controller;
  localparam int TIMEOUT = 15;
  localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_X = 7, P_R = 8, P_NONE = 99;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] f3 = '0;
  logic       zero = 1'b0, sign_bit = 1'b0, mem_ready = 1'b0;

  logic       mem_req, mem_we, adr_sel, ir_we, pc_we, alu_sel, reg_we, instr_done, err;
  logic [1:0] pc_src, result_sel;
  logic [2:0] imm_sel, alu_op, state;
  logic [21:0] obs;

  int n_vec = 0;
  int n_mis = 0;

  // Immediate format and writeback source per legal opcode 0..13.
  int imm_of [0:13] = '{0, 0, 0, 0, 0, 0, 0, 1, 3, 2, 2, 2, 2, 4};
  int res_of [0:13] = '{0, 1, 0, 0, 0, 2, 3, 0, 3, 0, 0, 0, 0, 2};

  multicycle_controller #(.TIMEOUT(TIMEOUT), .WAIT_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_op(op), .i_f3(f3), .i_zero(zero),
    .i_sign_bit(sign_bit), .i_mem_ready(mem_ready),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_adr_sel(adr_sel), .o_ir_we(ir_we),
    .o_pc_we(pc_we), .o_pc_src(pc_src), .o_imm_sel(imm_sel), .o_alu_sel(alu_sel),
    .o_alu_op(alu_op), .o_reg_we(reg_we), .o_result_sel(result_sel),
    .o_instr_done(instr_done), .o_err(err), .o_state(state)
  );

  assign obs = {mem_req, mem_we, adr_sel, ir_we, pc_we, pc_src, imm_sel, alu_sel,
                alu_op, reg_we, result_sel, instr_done, err, state};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [21:0] got, input logic [21:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (op=%0d t=%0t)", tag, got, exp, op, $time);
    end
  endtask

  // Expected outputs for one cycle given the phase the instruction is in.
  function automatic logic [21:0] model(input int ph, input logic [6:0] o, input logic [2:0] f,
                                        input logic z, input logic s, input logic r);
    logic req, we, adr, irwe, pcwe, asel, rwe, done, er;
    logic [1:0] src, res;
    logic [2:0] imm, aop, st;
    bit br, tk;
    int oi;
    {req, we, adr, irwe, pcwe, asel, rwe, done, er} = 9'b0;
    src = '0; res = '0; imm = '0; aop = '0; st = '0;
    oi = int'(o);
    br = (oi >= 9 && oi <= 12);
    tk = (oi == 9 && z) || (oi == 10 && !z) || (oi == 11 && s) || (oi == 12 && !s);
    case (ph)
      P_F: begin req = 1; irwe = r; pcwe = r; st = 3'd0; end
      P_D: begin st = 3'd1; if (oi <= 13) imm = 3'(imm_of[oi]); end
      P_E: begin
        st = 3'd2;
        imm = 3'(imm_of[oi]);
        asel = (oi >= 1 && oi <= 7);
        if (oi == 0 || oi == 3 || oi == 4) aop = f;
        else if (oi == 5 || br) aop = 3'd1;
        if (br) begin pcwe = tk; src = 2'd1; done = 1; end
        else if (oi == 8) begin pcwe = 1; src = 2'd1; end
        else if (oi == 6) begin pcwe = 1; src = 2'd2; end
      end
      P_M: begin st = 3'd3; req = 1; adr = 1; we = (oi == 7); done = (oi == 7) && r; end
      P_W: begin st = 3'd4; rwe = 1; done = 1; res = 2'(res_of[oi]); end
      P_X: begin st = 3'd7; er = 1; end
      default: ;
    endcase
    return {req, we, adr, irwe, pcwe, src, imm, asel, aop, rwe, res, done, er, st};
  endfunction

  // One clock: drive inputs, check at the falling edge, optionally pulse rst mid-cycle.
  task automatic cyc(input string tag, input int ph, input logic r, input logic z,
                     input logic s, input bit abort);
    mem_ready = r; zero = z; sign_bit = s;
    @(negedge clk);
    chk(tag, obs, model(ph, op, f3, z, s, r));
    if (abort) begin
      #1 rst = 1'b1;
      #1 chk("rst_gate", obs, 22'h0);
      @(posedge clk);
      #1 rst = 1'b0;
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) cyc("reset", P_R, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    rst = 1'b0;
  endtask

  task automatic err_hold();
    repeat (4) cyc("err_hold", P_X, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    do_reset();
  endtask

  // Request phase: ready arrives after w stalled cycles; st=1 timeout, st=2 aborted.
  task automatic req_phase(input int ph, input int w, input bit abort, output int st);
    logic r;
    bit ab;
    st = 0;
    for (int k = 0; k < 64; k++) begin
      r  = (k == w);
      ab = abort && (k == 0);
      cyc(ph == P_F ? "fetch" : "mem", ph, r, 1'($urandom), 1'($urandom), ab);
      if (ab) begin st = 2; return; end
      if (r) return;
      if (k == TIMEOUT - 1) begin st = 1; return; end
    end
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f, input int wf, input int wm,
                           input logic z, input logic s, input int abort_ph);
    int st;
    int oi;
    oi = int'(o);
    op = o; f3 = f;
    req_phase(P_F, wf, abort_ph == P_F, st);
    if (st == 1) begin err_hold(); return; end
    if (st == 2) return;
    cyc("decode", P_D, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    if (oi > 13) begin err_hold(); return; end
    cyc("exec", P_E, 1'($urandom), z, s, 1'b0);
    if (oi >= 9 && oi <= 12) return;
    if (oi == 1 || oi == 7) begin
      req_phase(P_M, wm, abort_ph == P_M, st);
      if (st == 1) begin err_hold(); return; end
      if (st == 2) return;
      if (oi == 7) return;
    end
    cyc("wb", P_W, 1'($urandom), 1'($urandom), 1'($urandom), abort_ph == P_W);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wf, wm;
    logic [6:0] o;
    rst = 1'b1;
    repeat (3) cyc("reset", P_R, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    rst = 1'b0;

    run_instr(7'd0,  3'd0, 0, 0, 1'b0, 1'b0, P_NONE);   // ADD
    run_instr(7'd0,  3'd6, 1, 0, 1'b0, 1'b0, P_NONE);   // R with f3 passthrough
    run_instr(7'd1,  3'd2, 0, 3, 1'b0, 1'b0, P_NONE);   // LW, 3 waits in MEM
    run_instr(7'd9,  3'd0, 0, 0, 1'b1, 1'b0, P_NONE);   // BEQ taken
    run_instr(7'd10, 3'd1, 0, 0, 1'b1, 1'b0, P_NONE);   // BNE not taken
    run_instr(7'd11, 3'd4, 0, 0, 1'b0, 1'b1, P_NONE);   // BLT taken
    run_instr(7'd12, 3'd5, 0, 0, 1'b0, 1'b1, P_NONE);   // BGE not taken
    run_instr(7'd0,  3'd0, 40, 0, 1'b0, 1'b0, P_NONE);  // FETCH timeout
    run_instr(7'd2,  3'd0, 14, 0, 1'b0, 1'b0, P_NONE);  // ready on 15th request cycle
    run_instr(7'd1,  3'd0, 0, 14, 1'b0, 1'b0, P_NONE);  // MEM ready on 15th
    run_instr(7'd7,  3'd2, 0, 30, 1'b0, 1'b0, P_NONE);  // MEM timeout
    run_instr(7'h7f, 3'd0, 0, 0, 1'b0, 1'b0, P_NONE);   // illegal opcode
    run_instr(7'd7,  3'd2, 0, 3, 1'b0, 1'b0, P_M);      // rst mid-MEM of SW
    run_instr(7'd1,  3'd2, 0, 0, 1'b0, 1'b0, P_W);      // rst mid-WB of LW
    run_instr(7'd13, 3'd0, 0, 0, 1'b0, 1'b0, P_NONE);   // LUI after reset

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 24) == 0) o = 7'($urandom_range(14, 127));
      else                            o = 7'($urandom_range(0, 13));
      wf = ($urandom_range(0, 19) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
      wm = ($urandom_range(0, 19) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
      run_instr(o, 3'($urandom), wf, wm, 1'($urandom), 1'($urandom), P_NONE);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
